// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared op encoding and arbiter types.
// op_t bit positions, arb_state_t FSM states, arb_tag_t tag-pipe entry.
package multi_counter_pkg;

  localparam int OP_W        = 3;
  localparam int OP_UPD_B    = 0;
  localparam int OP_OUTPUT_B = 1;
  localparam int OP_SET_B    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_INCR = 3'b001,
    OP_QRY  = 3'b010,
    OP_INIT = 3'b100
  } op_t;

  typedef enum logic {
    ARB_INIT,
    ARB_RUN
  } arb_state_t;

  // Wide enough for up to 16 requesters.
  localparam int ARB_IDX_W = 4;

  typedef struct packed {
    logic                 vld;
    logic                 qry;
    logic [ARB_IDX_W-1:0] req_idx;
  } arb_tag_t;

endpackage

// File: rtl/multi_counter_arb_if.sv
// multi_counter_arb_if: requester-side bus of multi_counter_arb.
// req_vld/req_rdy/req_id/req_op/req_dat in, rsp_vld/rsp_id/rsp_dat out.
interface multi_counter_arb_if #(
  parameter int REQ_N      = 4,
  parameter int CNTRS_ID_W = 8,
  parameter int CNTRS_W    = 32
);
  import multi_counter_pkg::*;

  logic [REQ_N-1:0]                 req_vld;
  logic [REQ_N-1:0]                 req_rdy;
  logic [REQ_N-1:0][CNTRS_ID_W-1:0] req_id;
  logic [REQ_N-1:0][OP_W-1:0]       req_op;
  logic [REQ_N-1:0][CNTRS_W-1:0]    req_dat;
  logic [REQ_N-1:0]                 rsp_vld;
  logic [CNTRS_ID_W-1:0]            rsp_id;
  logic [CNTRS_W-1:0]               rsp_dat;

  modport master (
    output req_vld, req_id, req_op, req_dat,
    input  req_rdy, rsp_vld, rsp_id, rsp_dat
  );

  modport slave (
    input  req_vld, req_id, req_op, req_dat,
    output req_rdy, rsp_vld, rsp_id, rsp_dat
  );

endinterface

// File: rtl/multi_counter_rr_arb.sv
// multi_counter_rr_arb: REQ_N round-robin grant, pointer moves past winner.
// Ports: vld_i requests, adv_i accept strobe, gnt_o one-hot, idx_o encoded.
module multi_counter_rr_arb #(
  parameter int REQ_N = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] vld_i,
  input  logic             adv_i,
  output logic [REQ_N-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(REQ_N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(REQ_N - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   j;
  logic             found;

  // Search from the pointer upward, wrapping at REQ_N.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < REQ_N; k++) begin
      j = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (j >= NREQ) j = j - NREQ;
      if (!found && vld_i[j[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = j[IDX_W-1:0];
        gnt_o[j[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (idx_o == LAST) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_counter_arb.sv
// multi_counter_arb: round-robin front end sharing multi_counter's command port.
// bus (slave) = requester channels/responses; cntr_* out, status_* in;
// init_done, sticky err_r. MULTI_COUNTER_ARB_INIT_EN enables the init sweep.
module multi_counter_arb
  import multi_counter_pkg::*;
#(
  parameter int REQ_N      = 4,
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int LAT        = 4,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int REQ_ID_W   = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_counter_arb_if.slave    bus,
  output logic                  init_done,
  output logic                  err_r,
  output logic                  cntr_pass,
  output logic [CNTRS_ID_W-1:0] cntr_id,
  output op_t                   cntr_op,
  output logic [CNTRS_W-1:0]    cntr_dat,
  input  logic                  status_pass_r,
  input  logic                  status_qry_r,
  input  logic [CNTRS_ID_W-1:0] status_id_r,
  input  logic [CNTRS_W-1:0]    status_dat_r
);

`ifdef MULTI_COUNTER_ARB_INIT_EN
  localparam arb_state_t RST_ST = ARB_INIT;
  localparam logic [CNTRS_ID_W-1:0] LAST_ID = CNTRS_ID_W'(CNTRS_N - 1);
  logic [CNTRS_ID_W-1:0] sweep_q;
`else
  localparam arb_state_t RST_ST = ARB_RUN;
`endif

  arb_state_t            state_q;
  logic                  init_q;
  logic                  pass_q;
  logic [CNTRS_ID_W-1:0] id_q;
  op_t                   op_q;
  logic [CNTRS_W-1:0]    dat_q;
  logic [REQ_ID_W-1:0]   idx_q;

  arb_tag_t              tag_q [LAT];
  arb_tag_t              tag_new;
  arb_tag_t              tag_out;
  logic [REQ_ID_W-1:0]   tag_idx;

  logic [REQ_N-1:0]      rsp_vld_q;
  logic [REQ_N-1:0]      rsp_vld_d;
  logic [CNTRS_ID_W-1:0] rsp_id_q;
  logic [CNTRS_W-1:0]    rsp_dat_q;
  logic                  err_q;

  logic [REQ_N-1:0]      vld_m;
  logic [REQ_N-1:0]      gnt;
  logic [REQ_ID_W-1:0]   win;
  op_t                   win_op;
  logic                  hs;
  logic                  hit;

  // No grants until init_done is visible to requesters.
  assign vld_m  = bus.req_vld & {REQ_N{init_q}};
  assign hs     = |gnt;
  assign win_op = op_t'(bus.req_op[win]);

  multi_counter_rr_arb #(
    .REQ_N (REQ_N),
    .IDX_W (REQ_ID_W)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (vld_m),
    .adv_i (hs),
    .gnt_o (gnt),
    .idx_o (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      init_q  <= 1'b0;
      pass_q  <= 1'b0;
      id_q    <= '0;
      op_q    <= OP_NOP;
      dat_q   <= '0;
      idx_q   <= '0;
`ifdef MULTI_COUNTER_ARB_INIT_EN
      sweep_q <= '0;
`endif
    end else begin
      init_q <= (state_q == ARB_RUN);
      unique case (state_q)
        ARB_INIT: begin
`ifdef MULTI_COUNTER_ARB_INIT_EN
          pass_q  <= 1'b1;
          id_q    <= sweep_q;
          op_q    <= OP_INIT;
          dat_q   <= '0;
          idx_q   <= '0;
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LAST_ID) state_q <= ARB_RUN;
`else
          state_q <= ARB_RUN;
`endif
        end
        ARB_RUN: begin
          if (hs) begin
            // NOP still consumes the grant but is not issued.
            pass_q <= (win_op != OP_NOP);
            id_q   <= bus.req_id[win];
            op_q   <= win_op;
            dat_q  <= bus.req_dat[win];
            idx_q  <= win;
          end else begin
            pass_q <= 1'b0;
          end
        end
        default: state_q <= RST_ST;
      endcase
    end
  end

  assign tag_new = '{
    vld:     pass_q,
    qry:     op_q[OP_OUTPUT_B],
    req_idx: ARB_IDX_W'(idx_q)
  };
  assign tag_out = tag_q[LAT-1];
  assign tag_idx = tag_out.req_idx[REQ_ID_W-1:0];
  assign hit     = tag_out.vld & tag_out.qry & status_qry_r;

  always_comb begin
    rsp_vld_d = '0;
    for (int i = 0; i < REQ_N; i++) begin
      rsp_vld_d[i] = hit && (tag_idx == REQ_ID_W'(i));
    end
  end

  // Tag entering stage 0 follows cntr_pass, so the last stage lines up
  // with status_pass_r LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      rsp_vld_q <= '0;
      rsp_id_q  <= '0;
      rsp_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tag_q[0] <= tag_new;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_vld_q <= rsp_vld_d;
      if (hit) begin
        rsp_id_q  <= status_id_r;
        rsp_dat_q <= status_dat_r;
      end
      if (tag_out.vld != status_pass_r) err_q <= 1'b1;
    end
  end

  assign bus.req_rdy = gnt;
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_dat = rsp_dat_q;
  assign init_done   = init_q;
  assign err_r       = err_q;
  assign cntr_pass   = pass_q;
  assign cntr_id     = id_q;
  assign cntr_op     = op_q;
  assign cntr_dat    = dat_q;

endmodule
